// File: rtl/program_sequencer_if.sv
// Bus bundle between the program sequencer, its program memory and the
// decode ROM: memory address/data, the instruction/HOLD pair handed to
// decode, the datapath flags and the stall request.
interface program_sequencer_if;
    logic [10:0] pm_addr;
    logic        pm_en;
    logic [21:0] pm_data;
    logic [21:0] instruction;
    logic        HOLD;
    logic        stall;
    logic        flag_z;
    logic        flag_cy;
    logic        stack_err;

    modport master (
        input  pm_data, stall, flag_z, flag_cy,
        output pm_addr, pm_en, instruction, HOLD, stack_err
    );

    modport slave (
        output pm_data, stall, flag_z, flag_cy,
        input  pm_addr, pm_en, instruction, HOLD, stack_err
    );
endinterface

// File: rtl/program_sequencer.sv
// Instruction fetch and sequencing stage. Keeps a three-slot pipeline
// (fetch address, memory read in flight, instruction register), resolves
// jumps, conditional jumps, subroutine calls and returns, and owns a
// circular hardware return stack.
module program_sequencer #(
    parameter int          STACK_DEPTH  = 4,
    parameter logic [10:0] RESET_VECTOR = 11'd0
) (
    input  logic clk,
    input  logic RESET,
    program_sequencer_if.master bus
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(STACK_DEPTH);

    localparam logic [10:0] OP_JUMP = 11'b10000000000;
    localparam logic [10:0] OP_JZE  = 11'b10100000000;
    localparam logic [10:0] OP_JNE  = 11'b11000000000;
    localparam logic [10:0] OP_JCY  = 11'b11100000000;
    localparam logic [11:0] OP_BSR  = 12'b011100000000;
    localparam logic [21:0] OP_RET  = 22'b0000011000000000000000;

    logic [10:0] fetch_pc;
    logic        f_valid;
    logic        m_valid;
    logic [10:0] m_pc;
    logic [21:0] instruction_q;
    logic        i_valid;
    logic [10:0] i_pc;

    logic [10:0]      stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             stack_err_q;

    logic             redirect;
    logic [10:0]      target;
    logic             push;
    logic             pop;
    logic             stack_empty;
    logic             stack_full;
    logic [PTR_W-1:0] top_idx;

    assign stack_empty = (count == '0);
    assign stack_full  = (count == FULL_COUNT);
    assign top_idx     = wr_ptr - 1'b1;

    // Decode the instruction register into a redirect decision, its target
    // and any return-stack push/pop; only a valid instruction can redirect.
    always_comb begin
        redirect = 1'b0;
        target   = '0;
        push     = 1'b0;
        pop      = 1'b0;
        if (i_valid) begin
            if (instruction_q[21:11] == OP_JUMP) begin
                redirect = 1'b1;
                target   = instruction_q[10:0];
            end else if (instruction_q[21:11] == OP_JZE) begin
                redirect = bus.flag_z;
                target   = instruction_q[10:0];
            end else if (instruction_q[21:11] == OP_JNE) begin
                redirect = ~bus.flag_z;
                target   = instruction_q[10:0];
            end else if (instruction_q[21:11] == OP_JCY) begin
                redirect = bus.flag_cy;
                target   = instruction_q[10:0];
            end else if (instruction_q[21:10] == OP_BSR) begin
                redirect = 1'b1;
                push     = 1'b1;
                target   = {1'b0, instruction_q[9:0]};
            end else if (instruction_q == OP_RET) begin
                redirect = 1'b1;
                pop      = 1'b1;
                target   = stack_empty ? RESET_VECTOR : stack_mem[top_idx];
            end
        end
    end

    // Advance the fetch/memory/instruction pipeline; a redirect squashes the
    // two younger slots and restarts fetch at the target. Stall freezes all.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            fetch_pc      <= RESET_VECTOR;
            f_valid       <= 1'b1;
            m_valid       <= 1'b0;
            m_pc          <= '0;
            instruction_q <= '0;
            i_valid       <= 1'b0;
            i_pc          <= '0;
        end else if (!bus.stall) begin
            f_valid       <= 1'b1;
            m_valid       <= f_valid & ~redirect;
            m_pc          <= fetch_pc;
            instruction_q <= bus.pm_data;
            i_pc          <= m_pc;
            i_valid       <= m_valid & ~redirect;
            fetch_pc      <= redirect ? target : fetch_pc + 11'd1;
        end
    end

    // Return-stack pointer and occupancy; a push on a full stack wraps over
    // the oldest entry, a pop on an empty stack leaves it empty, and both
    // raise the sticky error.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            wr_ptr      <= '0;
            count       <= '0;
            stack_err_q <= 1'b0;
        end else if (!bus.stall) begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (stack_full) begin
                    stack_err_q <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (pop) begin
                if (stack_empty) begin
                    stack_err_q <= 1'b1;
                end else begin
                    wr_ptr <= top_idx;
                    count  <= count - 1'b1;
                end
            end
        end
    end

    // Return-address storage; the entry is written at the current pointer.
    always_ff @(posedge clk) begin
        if (!RESET && !bus.stall && push) begin
            stack_mem[wr_ptr] <= i_pc + 11'd1;
        end
    end

    assign bus.pm_addr     = fetch_pc;
    assign bus.pm_en       = ~bus.stall;
    assign bus.instruction = instruction_q;
    assign bus.HOLD        = ~i_valid | bus.stall | RESET;
    assign bus.stack_err   = stack_err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed testbench for program_sequencer: a behavioural synchronous
// program memory feeds the sequencer and each step checks the outputs
// halfway through the clock period.
module tb_program_sequencer;

    logic clk;
    logic RESET;
    int   checks;
    int   errors;

    logic [21:0] pm [0:2047];

    program_sequencer_if bus ();

    program_sequencer #(
        .STACK_DEPTH  (4),
        .RESET_VECTOR (11'd0)
    ) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous program memory: data appears after the enabled posedge.
    always @(posedge clk) begin
        if (bus.pm_en) begin
            bus.pm_data <= pm[bus.pm_addr];
        end
    end

    function automatic logic [21:0] filler(input logic [10:0] a);
        return 22'h100000 | {11'd0, a};
    endfunction

    function automatic logic [21:0] enc_bsr(input logic [9:0] t);
        return {12'b011100000000, t};
    endfunction

    localparam logic [21:0] RET_WORD = 22'b0000011000000000000000;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart();
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
        step(2);
    endtask

    task automatic run_cond(input string tag, input logic [21:0] word,
                            input logic z, input logic cy, input logic taken,
                            input logic [10:0] tgt);
        pm[0] = word;
        bus.flag_z  = ~z;
        bus.flag_cy = ~cy;
        restart();
        bus.flag_z  = z;
        bus.flag_cy = cy;
        check({tag, "_instr"}, 32'(bus.instruction), 32'(word));
        step(1);
        if (taken) begin
            check({tag, "_hold1"}, 32'(bus.HOLD), 32'd1);
            check({tag, "_target"}, 32'(bus.pm_addr), 32'(tgt));
            step(1);
            check({tag, "_hold2"}, 32'(bus.HOLD), 32'd1);
            step(1);
            check({tag, "_landed"}, 32'(bus.instruction), 32'(pm[tgt]));
            check({tag, "_run"}, 32'(bus.HOLD), 32'd0);
        end else begin
            check({tag, "_fall"}, 32'(bus.instruction), 32'(pm[1]));
            check({tag, "_nobubble"}, 32'(bus.HOLD), 32'd0);
            step(1);
            check({tag, "_next"}, 32'(bus.instruction), 32'(pm[2]));
        end
        pm[0] = filler(11'd0);
    endtask

    // Directed scenarios run back to back.
    initial begin
        logic [10:0] nest_seq [11];
        checks      = 0;
        errors      = 0;
        RESET       = 1'b1;
        bus.stall   = 1'b0;
        bus.flag_z  = 1'b0;
        bus.flag_cy = 1'b0;
        for (int i = 0; i < 2048; i++) pm[i] = filler(11'(i));

        // Reset state and start-up latency, then an unconditional jump.
        pm[2] = {11'b10000000000, 11'h150};
        step(2);
        check("rst_hold", 32'(bus.HOLD), 32'd1);
        check("rst_addr", 32'(bus.pm_addr), 32'd0);
        check("rst_instr", 32'(bus.instruction), 32'd0);
        check("rst_err", 32'(bus.stack_err), 32'd0);
        check("rst_pm_en", 32'(bus.pm_en), 32'd1);
        RESET = 1'b0;
        step(1);
        check("boot_hold", 32'(bus.HOLD), 32'd1);
        check("boot_addr", 32'(bus.pm_addr), 32'd1);
        step(1);
        check("boot_hold_low", 32'(bus.HOLD), 32'd0);
        check("boot_pm0", 32'(bus.instruction), 32'(pm[0]));
        check("boot_addr2", 32'(bus.pm_addr), 32'd2);
        step(1);
        check("seq_pm1", 32'(bus.instruction), 32'(pm[1]));
        check("seq_addr3", 32'(bus.pm_addr), 32'd3);
        step(1);
        check("jmp_in_i", 32'(bus.instruction), 32'(pm[2]));
        check("jmp_valid", 32'(bus.HOLD), 32'd0);
        step(1);
        check("jmp_hold1", 32'(bus.HOLD), 32'd1);
        check("jmp_addr", 32'(bus.pm_addr), 32'h150);
        step(1);
        check("jmp_hold2", 32'(bus.HOLD), 32'd1);
        check("jmp_addr2", 32'(bus.pm_addr), 32'h151);
        step(1);
        check("jmp_landed", 32'(bus.instruction), 32'(pm[11'h150]));
        check("jmp_run", 32'(bus.HOLD), 32'd0);
        step(1);
        check("jmp_next", 32'(bus.instruction), 32'(pm[11'h151]));
        pm[2] = filler(11'd2);

        // Conditional jumps, each not taken and taken.
        run_cond("jze_nt", {11'b10100000000, 11'h020}, 1'b0, 1'b0, 1'b0, 11'h020);
        run_cond("jze_t",  {11'b10100000000, 11'h020}, 1'b1, 1'b0, 1'b1, 11'h020);
        run_cond("jne_nt", {11'b11000000000, 11'h030}, 1'b1, 1'b0, 1'b0, 11'h030);
        run_cond("jne_t",  {11'b11000000000, 11'h030}, 1'b0, 1'b0, 1'b1, 11'h030);
        run_cond("jcy_nt", {11'b11100000000, 11'h040}, 1'b0, 1'b0, 1'b0, 11'h040);
        run_cond("jcy_t",  {11'b11100000000, 11'h040}, 1'b0, 1'b1, 1'b1, 11'h040);
        bus.flag_z  = 1'b0;
        bus.flag_cy = 1'b0;

        // Subroutine call from address 5 and return to address 6.
        pm[5]      = enc_bsr(10'h040);
        pm[11'h40] = RET_WORD;
        restart();
        step(5);
        check("bsr_in_i", 32'(bus.instruction), 32'(pm[5]));
        step(1);
        check("bsr_hold", 32'(bus.HOLD), 32'd1);
        check("bsr_addr", 32'(bus.pm_addr), 32'h040);
        step(2);
        check("ret_in_i", 32'(bus.instruction), 32'(RET_WORD));
        step(1);
        check("ret_addr", 32'(bus.pm_addr), 32'd6);
        step(2);
        check("ret_landed", 32'(bus.instruction), 32'(pm[6]));
        check("ret_err", 32'(bus.stack_err), 32'd0);
        pm[5]      = filler(11'd5);
        pm[11'h40] = filler(11'h040);

        // Five nested calls on a four-deep stack, then five returns.
        pm[0]       = enc_bsr(10'h100);
        pm[11'h100] = enc_bsr(10'h110);
        pm[11'h110] = enc_bsr(10'h120);
        pm[11'h120] = enc_bsr(10'h130);
        pm[11'h130] = enc_bsr(10'h140);
        pm[11'h140] = RET_WORD;
        pm[11'h131] = RET_WORD;
        pm[11'h121] = RET_WORD;
        pm[11'h111] = RET_WORD;
        pm[11'h101] = RET_WORD;
        nest_seq = '{11'h000, 11'h100, 11'h110, 11'h120, 11'h130, 11'h140,
                     11'h131, 11'h121, 11'h111, 11'h101, 11'h000};
        restart();
        check("nest_start", 32'(bus.instruction), 32'(pm[0]));
        for (int i = 1; i < 11; i++) begin
            step(3);
            check($sformatf("nest_instr%0d", i), 32'(bus.instruction),
                  32'(pm[nest_seq[i]]));
            check($sformatf("nest_err%0d", i), 32'(bus.stack_err),
                  (i >= 5) ? 32'd1 : 32'd0);
        end
        pm[0] = filler(11'd0);

        // Return with an empty stack goes to the reset vector.
        pm[3] = RET_WORD;
        restart();
        check("empty_err0", 32'(bus.stack_err), 32'd0);
        step(3);
        check("empty_ret", 32'(bus.instruction), 32'(RET_WORD));
        step(1);
        check("empty_addr", 32'(bus.pm_addr), 32'd0);
        check("empty_err1", 32'(bus.stack_err), 32'd1);
        step(2);
        check("empty_landed", 32'(bus.instruction), 32'(pm[0]));
        pm[3] = filler(11'd3);

        // Reset pulsed mid-stream clears state at once and restarts at 0.
        step(2);
        RESET = 1'b1;
        #1;
        check("mid_rst_hold", 32'(bus.HOLD), 32'd1);
        check("mid_rst_addr", 32'(bus.pm_addr), 32'd0);
        check("mid_rst_instr", 32'(bus.instruction), 32'd0);
        check("mid_rst_err", 32'(bus.stack_err), 32'd0);
        step(1);
        RESET = 1'b0;
        step(2);
        check("mid_rst_pm0", 32'(bus.instruction), 32'(pm[0]));
        check("mid_rst_run", 32'(bus.HOLD), 32'd0);

        // Stall held three cycles with a conditional jump in I while the flag
        // changes; the decision uses the flag at the first unstalled edge.
        pm[2] = {11'b10100000000, 11'h200};
        bus.flag_z = 1'b0;
        restart();
        step(2);
        check("stall_jze", 32'(bus.instruction), 32'(pm[2]));
        bus.stall = 1'b1;
        #1;
        check("stall_hold_now", 32'(bus.HOLD), 32'd1);
        check("stall_pm_en", 32'(bus.pm_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.flag_z = i[0];
            step(1);
            check($sformatf("stall_instr%0d", i), 32'(bus.instruction), 32'(pm[2]));
            check($sformatf("stall_addr%0d", i), 32'(bus.pm_addr), 32'd4);
            check($sformatf("stall_hold%0d", i), 32'(bus.HOLD), 32'd1);
        end
        bus.flag_z = 1'b1;
        bus.stall  = 1'b0;
        #1;
        check("unstall_hold", 32'(bus.HOLD), 32'd0);
        step(1);
        check("unstall_redirect", 32'(bus.pm_addr), 32'h200);
        check("unstall_hold1", 32'(bus.HOLD), 32'd1);
        step(2);
        check("unstall_landed", 32'(bus.instruction), 32'(pm[11'h200]));
        pm[2] = filler(11'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
